// File: rtl/sort_pkg.sv
// Shared types for the sort-order checker: FSM state and the per-packet status record.
package sort_pkg;

  localparam int unsigned StatLenW = 16;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBody = 1'b1
  } state_e;

  typedef struct packed {
    logic [StatLenW-1:0] length;
    logic                err_order;
    logic                err_frame;
    logic                err_len;
    logic                err_orphan;
  } stat_t;

  function automatic logic stat_has_err(stat_t s);
    return s.err_order | s.err_frame | s.err_len | s.err_orphan;
  endfunction

endpackage

// File: rtl/sort_checker_if.sv
// Word stream with packet markers; no backpressure, so there is no ready signal.
interface sort_checker_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  valid;
  logic                  sop;
  logic                  eop;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, sop, eop, data);
  modport slave  (input  valid, sop, eop, data);

endinterface

// File: rtl/sort_sat_counter.sv
// Saturating up-counter; a synchronous clear overrides an increment in the same cycle.
module sort_sat_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear_i,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/sort_checker.sv
// Checks that each packet on a sorter output is non-decreasing and well framed, passes the
// stream through with one cycle of delay, and reports a status strobe per closed packet.
module sort_checker
  import sort_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_LENGTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  sort_checker_if.slave                 snk,
  sort_checker_if.master                src,
  input  logic                          clear,
  output logic                          stat_valid,
  output logic [$clog2(MAX_LENGTH)+1:0] stat_length,
  output logic                          stat_err_order,
  output logic                          stat_err_frame,
  output logic                          stat_err_len,
  output logic                          stat_err_orphan,
  output logic [CNT_WIDTH-1:0]          pkt_count,
  output logic [CNT_WIDTH-1:0]          err_count
);

  localparam int unsigned LenW = $clog2(MAX_LENGTH) + 2;
  localparam logic [LenW-1:0] LenSat = LenW'(MAX_LENGTH + 1);

  function automatic stat_t mk_stat(logic [LenW-1:0] len, logic order, logic frame,
                                    logic orphan);
    stat_t s;
    s.length     = StatLenW'(len);
    s.err_order  = order;
    s.err_frame  = frame;
    s.err_len    = (len > LenW'(MAX_LENGTH));
    s.err_orphan = orphan;
    return s;
  endfunction

  state_e                state_d, state_q;
  logic [LenW-1:0]       len_d, len_q, len_inc;
  logic [DATA_WIDTH-1:0] last_d, last_q;
  logic                  order_d, order_q, order_inc;
  stat_t                 close_a, close_b;
  logic [1:0]            n_close;

  stat_t                 stat_d, stat_q, pend_d, pend_q;
  logic                  stat_valid_d, stat_valid_q, pend_valid_d, pend_valid_q;

  logic                  src_valid_q, src_sop_q, src_eop_q;
  logic [DATA_WIDTH-1:0] src_data_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    last_d    = last_q;
    order_d   = order_q;
    close_a   = '0;
    close_b   = '0;
    n_close   = 2'd0;
    len_inc   = (len_q == LenSat) ? len_q : len_q + LenW'(1);
    order_inc = order_q | (snk.data < last_q);
    if (snk.valid) begin
      unique case (state_q)
        StIdle: begin
          if (!snk.sop) begin
            close_a = mk_stat('0, 1'b0, 1'b0, 1'b1);
            n_close = 2'd1;
          end else if (snk.eop) begin
            close_a = mk_stat(LenW'(1), 1'b0, 1'b0, 1'b0);
            n_close = 2'd1;
          end else begin
            state_d = StBody;
            len_d   = LenW'(1);
            last_d  = snk.data;
            order_d = 1'b0;
          end
        end
        StBody: begin
          if (snk.sop) begin
            // An early sop aborts the open packet and starts the next one in this cycle.
            close_a = mk_stat(len_q, order_q, 1'b1, 1'b0);
            len_d   = LenW'(1);
            last_d  = snk.data;
            order_d = 1'b0;
            if (snk.eop) begin
              close_b = mk_stat(LenW'(1), 1'b0, 1'b0, 1'b0);
              n_close = 2'd2;
              state_d = StIdle;
            end else begin
              n_close = 2'd1;
            end
          end else begin
            len_d   = len_inc;
            order_d = order_inc;
            last_d  = snk.data;
            if (snk.eop) begin
              close_a = mk_stat(len_inc, order_inc, 1'b0, 1'b0);
              n_close = 2'd1;
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // A double close can only follow a cycle that leaves IDLE, so one pending slot is enough.
  always_comb begin
    stat_d       = stat_q;
    stat_valid_d = 1'b0;
    pend_d       = pend_q;
    pend_valid_d = 1'b0;
    case (n_close)
      2'd2: begin
        stat_d       = close_a;
        stat_valid_d = 1'b1;
        pend_d       = close_b;
        pend_valid_d = 1'b1;
      end
      2'd1: begin
        stat_valid_d = 1'b1;
        if (pend_valid_q) begin
          stat_d       = pend_q;
          pend_d       = close_a;
          pend_valid_d = 1'b1;
        end else begin
          stat_d = close_a;
        end
      end
      default: begin
        if (pend_valid_q) begin
          stat_d       = pend_q;
          stat_valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      len_q        <= '0;
      last_q       <= '0;
      order_q      <= 1'b0;
      stat_q       <= '0;
      stat_valid_q <= 1'b0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      src_valid_q  <= 1'b0;
      src_sop_q    <= 1'b0;
      src_eop_q    <= 1'b0;
      src_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      last_q       <= last_d;
      order_q      <= order_d;
      stat_q       <= stat_d;
      stat_valid_q <= stat_valid_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      src_valid_q  <= snk.valid;
      src_sop_q    <= snk.sop;
      src_eop_q    <= snk.eop;
      src_data_q   <= snk.data;
    end
  end

  sort_sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_pkt_cnt (
    .clock  (clock),
    .reset_n(reset_n),
    .clear_i(clear),
    .inc_i  (stat_valid_q),
    .count_o(pkt_count)
  );

  sort_sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_err_cnt (
    .clock  (clock),
    .reset_n(reset_n),
    .clear_i(clear),
    .inc_i  (stat_valid_q & stat_has_err(stat_q)),
    .count_o(err_count)
  );

  if (StatLenW > LenW) begin : g_len_unused
    logic unused_len;
    assign unused_len = ^stat_q.length[StatLenW-1:LenW];
  end

  assign src.valid       = src_valid_q;
  assign src.sop         = src_sop_q;
  assign src.eop         = src_eop_q;
  assign src.data        = src_data_q;
  assign stat_valid      = stat_valid_q;
  assign stat_length     = stat_q.length[LenW-1:0];
  assign stat_err_order  = stat_q.err_order;
  assign stat_err_frame  = stat_q.err_frame;
  assign stat_err_len    = stat_q.err_len;
  assign stat_err_orphan = stat_q.err_orphan;

endmodule

// File: tb/tb_sort_checker.sv
// Scoreboard bench for sort_checker: packets are modelled as word lists, expected status is
// queued at issue time, and a monitor pops one entry per strobe.
module tb_sort_checker;

  localparam int unsigned DW = 8;
  localparam int unsigned ML = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned LW = $clog2(ML) + 2;
  localparam int MaxCnt = (1 << CW) - 1;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear   = 1'b0;
  logic          stat_valid;
  logic [LW-1:0] stat_length;
  logic          stat_err_order, stat_err_frame, stat_err_len, stat_err_orphan;
  logic [CW-1:0] pkt_count, err_count;

  sort_checker_if #(.DATA_WIDTH(DW)) snk_if ();
  sort_checker_if #(.DATA_WIDTH(DW)) src_if ();

  sort_checker #(
    .DATA_WIDTH(DW),
    .MAX_LENGTH(ML),
    .CNT_WIDTH (CW)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .snk            (snk_if),
    .src            (src_if),
    .clear          (clear),
    .stat_valid     (stat_valid),
    .stat_length    (stat_length),
    .stat_err_order (stat_err_order),
    .stat_err_frame (stat_err_frame),
    .stat_err_len   (stat_err_len),
    .stat_err_orphan(stat_err_orphan),
    .pkt_count      (pkt_count),
    .err_count      (err_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int len;
    bit order;
    bit frame;
    bit lerr;
    bit orphan;
  } exp_t;

  exp_t          sb[$];
  int            checks  = 0;
  int            passes  = 0;
  int            exp_pkt = 0;
  int            exp_err = 0;
  logic [DW-1:0] pkt_w[16];
  int            pkt_n   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int sat_inc(input int v);
    return (v >= MaxCnt) ? MaxCnt : v + 1;
  endfunction

  task automatic expect_stat(input int n, input bit order, input bit frame, input bit orphan);
    exp_t e;
    e.len    = orphan ? 0 : ((n > int'(ML)) ? int'(ML) + 1 : n);
    e.order  = order;
    e.frame  = frame;
    e.lerr   = !orphan && (n > int'(ML));
    e.orphan = orphan;
    sb.push_back(e);
    exp_pkt = sat_inc(exp_pkt);
    if (e.order || e.frame || e.lerr || e.orphan) exp_err = sat_inc(exp_err);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Markers and data are randomised on idle cycles: the DUT must ignore them.
  task automatic idle_inputs();
    snk_if.valid = 1'b0;
    snk_if.sop   = 1'($urandom);
    snk_if.eop   = 1'($urandom);
    snk_if.data  = DW'($urandom);
  endtask

  task automatic drive_word(input bit sop, input bit eop, input logic [DW-1:0] d);
    snk_if.valid = 1'b1;
    snk_if.sop   = sop;
    snk_if.eop   = eop;
    snk_if.data  = d;
    tick();
    idle_inputs();
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic load_words(input int n, input logic [63:0] v);
    pkt_n = n;
    for (int i = 0; i < n; i++) pkt_w[i] = v[8*i +: 8];
  endtask

  // A truncated packet has no eop; the next packet's sop closes it with a frame error.
  task automatic send_packet(input bit trunc, input int maxgap);
    bit ord;
    ord = 1'b0;
    for (int i = 1; i < pkt_n; i++) if (pkt_w[i] < pkt_w[i-1]) ord = 1'b1;
    expect_stat(pkt_n, ord, trunc, 1'b0);
    for (int i = 0; i < pkt_n; i++) begin
      drive_word(i == 0, (i == pkt_n - 1) && !trunc, pkt_w[i]);
      if (i < pkt_n - 1) gap($urandom_range(0, maxgap));
    end
  endtask

  task automatic send_orphan(input logic [DW-1:0] d);
    expect_stat(0, 1'b0, 1'b0, 1'b1);
    drive_word(1'b0, 1'($urandom), d);
  endtask

  task automatic check_counters(input string tag);
    gap(4);
    @(negedge clock);
    check({tag, "_pkt_count"}, pkt_count, exp_pkt);
    check({tag, "_err_count"}, err_count, exp_err);
    tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stat_valid"}, stat_valid, 0);
    check({tag, "_stat_length"}, stat_length, 0);
    check({tag, "_stat_flags"},
          {stat_err_order, stat_err_frame, stat_err_len, stat_err_orphan}, 0);
    check({tag, "_pkt_count"}, pkt_count, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_src"}, {src_if.valid, src_if.sop, src_if.eop, src_if.data}, 0);
  endtask

  logic [DW+2:0] prev_in  = '0;
  logic          prev_rst = 1'b0;

  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset_n && prev_rst)
      check("src_mirror", {src_if.valid, src_if.sop, src_if.eop, src_if.data}, prev_in);
    prev_in  <= {snk_if.valid, snk_if.sop, snk_if.eop, snk_if.data};
    prev_rst <= reset_n;
    if (reset_n && stat_valid) begin
      check("strobe_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("stat_length", stat_length, e.len);
        check("stat_flags", {stat_err_order, stat_err_frame, stat_err_len, stat_err_orphan},
              {e.order, e.frame, e.lerr, e.orphan});
      end
    end
  end

  initial begin : stimulus
    bit            must_pkt;
    bit            tr;
    bit            sorted;
    int            v;
    idle_inputs();
    #2;
    check_zero("reset");
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;

    load_words(4, 64'h07_03_03_01);
    send_packet(1'b0, 0);
    check_counters("sorted4");

    load_words(3, 64'h09_02_05);
    send_packet(1'b0, 0);
    check_counters("descent");

    // Early sop with sop&eop yields two strobes; an orphan right behind queues a third.
    load_words(2, 64'h06_04);
    send_packet(1'b1, 0);
    load_words(1, 64'h01);
    send_packet(1'b0, 0);
    send_orphan(8'hA5);
    check_counters("frame");

    pkt_n = 10;
    for (int i = 0; i < 10; i++) pkt_w[i] = DW'(10 + i);
    send_packet(1'b0, 1);
    check_counters("overlen");

    send_orphan(8'h5A);
    check_counters("orphan");

    clear = 1'b1;
    tick();
    clear   = 1'b0;
    exp_pkt = 0;
    exp_err = 0;
    check_counters("clear");

    repeat (16) send_orphan(DW'($urandom));
    check_counters("saturate");
    load_words(3, 64'h09_02_05);
    send_packet(1'b0, 0);
    check_counters("sat_hold");

    // The single-word strobe is live now; clear must beat its increment.
    load_words(1, 64'h33);
    send_packet(1'b0, 0);
    clear = 1'b1;
    tick();
    clear   = 1'b0;
    exp_pkt = 0;
    exp_err = 0;
    check("clear_vs_strobe_pkt", pkt_count, 0);
    check("clear_vs_strobe_err", err_count, 0);
    check_counters("after_clear");

    load_words(3, 64'h30_20_10);
    send_packet(1'b0, 0);
    check_counters("pre_reset");
    drive_word(1'b1, 1'b0, 8'h01);
    drive_word(1'b0, 1'b0, 8'h00);
    drive_word(1'b0, 1'b0, 8'h02);
    reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    exp_pkt = 0;
    exp_err = 0;
    tick();
    tick();
    reset_n = 1'b1;
    send_orphan(8'h77);
    check_counters("post_reset");

    clear = 1'b1;
    tick();
    clear    = 1'b0;
    exp_pkt  = 0;
    exp_err  = 0;
    must_pkt = 1'b0;
    for (int it = 0; it < 60; it++) begin
      if (!must_pkt && ($urandom_range(0, 4) == 0)) begin
        send_orphan(DW'($urandom));
      end else begin
        tr     = (it != 59) && ($urandom_range(0, 4) == 0);
        sorted = 1'($urandom_range(0, 1));
        pkt_n  = $urandom_range(1, 11);
        v      = $urandom_range(0, 40);
        for (int i = 0; i < pkt_n; i++) begin
          if (sorted) begin
            pkt_w[i] = DW'(v);
            v += $urandom_range(0, 15);
          end else begin
            pkt_w[i] = DW'($urandom);
          end
        end
        send_packet(tr, 2);
        must_pkt = tr;
      end
      gap($urandom_range(0, 2));
    end
    check_counters("random");

    gap(4);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
